// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - signed-digit encodings, mode codes, FSM states and digit helpers
package sd_pkg;

  localparam logic [1:0] SD_ZERO = 2'b00;
  localparam logic [1:0] SD_POS  = 2'b10;
  localparam logic [1:0] SD_NEG  = 2'b01;

  localparam logic [1:0] MODE_ADD  = 2'b00;
  localparam logic [1:0] MODE_SUB  = 2'b01;
  localparam logic [1:0] MODE_LOAD = 2'b10;
  localparam logic [1:0] MODE_CLR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [1:0] sd_neg(input logic [1:0] d);
    return {d[0], d[1]};
  endfunction

  // The illegal code 11 reads as zero here.
  function automatic logic signed [2:0] sd_val(input logic [1:0] d);
    case (d)
      SD_POS:  return 3'sd1;
      SD_NEG:  return -3'sd1;
      default: return 3'sd0;
    endcase
  endfunction

  function automatic logic [1:0] sd_enc(input logic signed [2:0] v);
    if (v > 0) return SD_POS;
    if (v < 0) return SD_NEG;
    return SD_ZERO;
  endfunction

endpackage

// File: rtl/sd_accum_conv_if.sv
// rtl/sd_accum_conv_if.sv - operand, conversion and status bundle of the accumulator
interface sd_accum_conv_if #(parameter int N = 8);

  logic           in_valid;
  logic           in_ready;
  logic [1:0]     in_mode;
  logic [2*N-1:0] in_op;
  logic           conv_req;
  logic           conv_busy;
  logic           out_valid;
  logic           out_ready;
  logic [N:0]     out_data;
  logic [2*N-1:0] acc_sd;
  logic           ovf;
  logic           sd_err;

  modport master (
    output in_valid, in_mode, in_op, conv_req, out_ready,
    input  in_ready, conv_busy, out_valid, out_data, acc_sd, ovf, sd_err
  );

  modport slave (
    input  in_valid, in_mode, in_op, conv_req, out_ready,
    output in_ready, conv_busy, out_valid, out_data, acc_sd, ovf, sd_err
  );

endinterface

// File: rtl/sd_digit_cell.sv
// rtl/sd_digit_cell.sv - carry-free signed-digit adder cell, x + y = 2*tout + w, s = w + tin
module sd_digit_cell
  import sd_pkg::*;
(
  input  logic [1:0] x,
  input  logic [1:0] y,
  input  logic [1:0] tin,
  input  logic       lin,
  output logic [1:0] s,
  output logic [1:0] tout,
  output logic       lout
);

  logic signed [2:0] p;
  logic signed [2:0] t;
  logic signed [2:0] w;

  // lin says the incoming transfer is in {-1,0}; otherwise it is in {0,+1}.
  always_comb begin
    p = sd_val(x) + sd_val(y);
    t = 3'sd0;
    w = 3'sd0;
    case (p)
      3'sd2:  t = 3'sd1;
      -3'sd2: t = -3'sd1;
      3'sd1: begin
        if (lin) begin
          w = 3'sd1;
        end else begin
          t = 3'sd1;
          w = -3'sd1;
        end
      end
      -3'sd1: begin
        if (lin) begin
          t = -3'sd1;
          w = 3'sd1;
        end else begin
          w = -3'sd1;
        end
      end
      default: ;
    endcase
    s    = sd_enc(w + sd_val(tin));
    tout = sd_enc(t);
  end

  assign lout = (x == SD_NEG) | (y == SD_NEG);

endmodule

// File: rtl/sd_accum_conv.sv
// rtl/sd_accum_conv.sv - signed-digit accumulator with chunked two's-complement conversion
module sd_accum_conv
  import sd_pkg::*;
#(
  parameter int N     = 8,
  parameter int CHUNK = 2
) (
  input logic          clk,
  input logic          rst_n,
  sd_accum_conv_if.slave bus
);

  localparam int NCH = N / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  state_e         state_q, state_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic           ovf_q, ovf_d;
  logic           err_q, err_d;
  logic [N-1:0]   p_q, p_d;
  logic [N-1:0]   m_q, m_d;
  logic           borrow_q, borrow_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N:0]     out_q, out_d;

  logic [2*N-1:0] op_clean;
  logic [2*N-1:0] y_op;
  logic [2*N-1:0] sum;
  logic [2*N-1:0] folded;
  logic [2*N+1:0] tk;
  logic [N:0]     lk;
  logic           lk_top_unused;
  logic           op_err;
  logic           fold_ovf;
  logic [N-1:0]   p_snap;
  logic [N-1:0]   m_snap;
  logic [CHUNK:0] diff;

  always_comb begin
    op_clean = '0;
    y_op     = '0;
    op_err   = 1'b0;
    p_snap   = '0;
    m_snap   = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.in_op[2*i +: 2] == 2'b11) op_err = 1'b1;
      else op_clean[2*i +: 2] = bus.in_op[2*i +: 2];
      y_op[2*i +: 2] = (bus.in_mode == MODE_SUB) ? sd_neg(op_clean[2*i +: 2])
                                                 : op_clean[2*i +: 2];
      p_snap[i] = acc_q[2*i+1];
      m_snap[i] = acc_q[2*i];
    end
  end

  assign tk[1:0]       = SD_ZERO;
  assign lk[0]         = 1'b0;
  assign lk_top_unused = lk[N];

  for (genvar gi = 0; gi < N; gi++) begin : g_cell
    sd_digit_cell u_cell (
      .x    (acc_q[2*gi +: 2]),
      .y    (y_op[2*gi +: 2]),
      .tin  (tk[2*gi +: 2]),
      .lin  (lk[gi]),
      .s    (sum[2*gi +: 2]),
      .tout (tk[2*gi+2 +: 2]),
      .lout (lk[gi+1])
    );
  end

  // A top transfer opposite to the MSB digit collapses into that digit exactly.
  always_comb begin
    folded   = sum;
    fold_ovf = 1'b0;
    if (tk[2*N+1:2*N] != SD_ZERO) begin
      if (sum[2*N-1:2*N-2] == sd_neg(tk[2*N+1:2*N])) folded[2*N-1:2*N-2] = tk[2*N+1:2*N];
      else fold_ovf = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    p_d      = p_q;
    m_d      = m_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    diff     = {1'b0, p_q[CHUNK-1:0]} - {1'b0, m_q[CHUNK-1:0]} - {{CHUNK{1'b0}}, borrow_q};
    case (state_q)
      ST_IDLE: begin
        if (bus.conv_req) begin
          p_d      = p_snap;
          m_d      = m_snap;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = ST_CONV;
        end else if (bus.in_valid) begin
          case (bus.in_mode)
            MODE_ADD, MODE_SUB: begin
              acc_d = folded;
              ovf_d = ovf_q | fold_ovf;
              err_d = err_q | op_err;
            end
            MODE_LOAD: begin
              acc_d = op_clean;
              err_d = err_q | op_err;
            end
            default: begin
              acc_d = '0;
              ovf_d = 1'b0;
              err_d = 1'b0;
            end
          endcase
        end
      end
      ST_CONV: begin
        // Result chunks shift in from the top so the first (LSB) chunk lands at bit 0.
        out_d    = {diff[CHUNK], diff[CHUNK-1:0], out_q[N-1:CHUNK]};
        borrow_d = diff[CHUNK];
        p_d      = p_q >> CHUNK;
        m_d      = m_q >> CHUNK;
        if (cnt_q == CW'(NCH - 1)) state_d = ST_DONE;
        else cnt_d = cnt_q + 1'b1;
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      p_q      <= '0;
      m_q      <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      p_q      <= p_d;
      m_q      <= m_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE) & ~bus.conv_req;
  assign bus.conv_busy = (state_q != ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out_data  = out_q;
  assign bus.acc_sd    = acc_q;
  assign bus.ovf       = ovf_q;
  assign bus.sd_err    = err_q;

endmodule

// File: tb/tb_sd_accum_conv.sv
// tb/tb_sd_accum_conv.sv - randomized and directed bench with an integer-digit reference model
module tb_sd_accum_conv;
  import sd_pkg::*;

  localparam int N     = 8;
  localparam int CHUNK = 2;
  localparam int NCH   = N / CHUNK;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sd_accum_conv_if #(.N(N)) bus ();

  sd_accum_conv #(.N(N), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: digits as integers in {-1,0,+1}, conversion as plain arithmetic.
  int         dig[N];
  int         opd[N];
  bit         m_ovf, m_err;
  int         phase;
  int         left;
  longint     snap;
  logic [N:0] m_out;

  function automatic longint dig_value();
    longint v = 0;
    for (int i = 0; i < N; i++) v += dig[i] * (longint'(1) << i);
    return v;
  endfunction

  function automatic logic [2*N-1:0] dig_enc();
    logic [2*N-1:0] e = '0;
    for (int i = 0; i < N; i++)
      e[2*i +: 2] = (dig[i] > 0) ? 2'b10 : (dig[i] < 0) ? 2'b01 : 2'b00;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) dig[i] = 0;
    m_ovf = 0; m_err = 0; phase = 0; left = 0; snap = 0; m_out = '0;
  endtask

  // Transfer t picked so w = p - 2t lies in {0,1} when a lower digit is negative, else {-1,0}.
  task automatic model_add();
    int r[N];
    int tprev = 0;
    for (int i = 0; i < N; i++) begin
      int p = dig[i] + opd[i];
      bit nb = (i > 0) && (dig[i-1] < 0 || opd[i-1] < 0);
      int t = nb ? ((p + 2) / 2 - 1) : (1 - (2 - p) / 2);
      r[i] = p - 2 * t + tprev;
      tprev = t;
    end
    if (tprev != 0) begin
      if (r[N-1] == -tprev) r[N-1] = tprev;
      else m_ovf = 1;
    end
    for (int i = 0; i < N; i++) dig[i] = r[i];
  endtask

  task automatic model_step();
    logic [1:0] code;
    bit bad = 0;
    case (phase)
      0: begin
        if (bus.conv_req) begin
          phase = 1; left = NCH; snap = dig_value();
        end else if (bus.in_valid) begin
          for (int i = 0; i < N; i++) begin
            code = bus.in_op[2*i +: 2];
            opd[i] = (code == 2'b10) ? 1 : (code == 2'b01) ? -1 : 0;
            if (code == 2'b11) bad = 1;
          end
          case (bus.in_mode)
            MODE_ADD: model_add();
            MODE_SUB: begin
              for (int i = 0; i < N; i++) opd[i] = -opd[i];
              model_add();
            end
            MODE_LOAD: for (int i = 0; i < N; i++) dig[i] = opd[i];
            default: begin
              for (int i = 0; i < N; i++) dig[i] = 0;
              m_ovf = 0; m_err = 0;
            end
          endcase
          if (bus.in_mode != MODE_CLR && bad) m_err = 1;
        end
      end
      1: begin
        left--;
        if (left == 0) begin
          phase = 2; m_out = snap[N:0];
        end
      end
      default: if (bus.out_ready) phase = 0;
    endcase
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      check("acc_sd", bus.acc_sd, dig_enc());
      check("ovf", bus.ovf, m_ovf);
      check("sd_err", bus.sd_err, m_err);
      check("in_ready", bus.in_ready, (phase == 0) && !bus.conv_req);
      check("conv_busy", bus.conv_busy, phase != 0);
      check("out_valid", bus.out_valid, phase == 2);
      if (phase != 1) check("out_data", bus.out_data, m_out);
      if (rst_n) model_step();
    end
  end

  task automatic do_op(input logic [1:0] mode, input logic [2*N-1:0] op);
    bus.in_valid = 1'b1; bus.in_mode = mode; bus.in_op = op;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic do_conv(input int hold, output logic [N:0] res, output int busy);
    int guard = 0;
    busy = 0;
    bus.conv_req = 1'b1;
    @(posedge clk); #1;
    bus.conv_req = 1'b0;
    while (!bus.out_valid && guard < 50) begin
      if (bus.conv_busy) busy++;
      @(posedge clk); #1;
      guard++;
    end
    check("conv_done", bus.out_valid, 1'b1);
    res = bus.out_data;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check("hold_valid", bus.out_valid, 1'b1);
      check("hold_data", bus.out_data, res);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("valid_drop", bus.out_valid, 1'b0);
  endtask

  function automatic logic [2*N-1:0] rand_op();
    logic [2*N-1:0] v = '0;
    for (int i = 0; i < N; i++) begin
      int r = $urandom_range(0, 19);
      v[2*i +: 2] = (r == 0) ? 2'b11 : (r < 7) ? 2'b10 : (r < 13) ? 2'b01 : 2'b00;
    end
    return v;
  endfunction

  logic [N:0] res;
  int         busy;

  initial begin
    bus.in_valid = 1'b0; bus.in_mode = 2'b00; bus.in_op = '0;
    bus.conv_req = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    do_op(MODE_LOAD, 16'h0022);
    do_op(MODE_ADD, 16'h0009);
    do_conv(3, res, busy);
    check("conv_cycles", busy, NCH);
    check("conv_5p1", res, 9'd6);

    do_op(MODE_LOAD, 16'h000A);
    do_op(MODE_SUB, 16'h0088);
    do_conv(1, res, busy);
    check("conv_3m10", res, 9'h1F9);

    do_op(MODE_LOAD, 16'hAAAA);
    check("ovf_before", bus.ovf, 1'b0);
    do_op(MODE_ADD, 16'h0002);
    check("ovf_set", bus.ovf, 1'b1);
    check("acc_wrap", bus.acc_sd, 16'h0000);
    do_op(MODE_ADD, 16'h0000);
    check("ovf_sticky", bus.ovf, 1'b1);
    do_op(MODE_CLR, 16'h0000);
    check("ovf_clr", bus.ovf, 1'b0);
    check("acc_clr", bus.acc_sd, 16'h0000);

    do_op(MODE_LOAD, 16'h00C2);
    check("sd_err_set", bus.sd_err, 1'b1);
    check("acc_illegal", bus.acc_sd, 16'h0002);
    do_conv(0, res, busy);
    check("conv_illegal", res, 9'd1);

    for (int c = 0; c < 400; c++) begin
      int r = $urandom_range(0, 15);
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_mode   = (r == 0) ? MODE_CLR : 2'(r % 3);
      bus.in_op     = rand_op();
      bus.conv_req  = ($urandom_range(0, 9) == 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0; bus.conv_req = 1'b0; bus.out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1 bus.out_ready = 1'b0;

    do_op(MODE_CLR, 16'h0000);
    do_op(MODE_LOAD, 16'h0022);
    do_conv(0, res, busy);
    check("conv_5", res, 9'd5);

    bus.in_valid = 1'b1; bus.in_mode = MODE_LOAD; bus.in_op = 16'h000A; bus.conv_req = 1'b1;
    #1 check("collide_ready", bus.in_ready, 1'b0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.conv_req = 1'b0;
    check("collide_busy", bus.conv_busy, 1'b1);
    check("collide_acc", bus.acc_sd, 16'h0022);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_valid", bus.out_valid, 1'b0);
    check("rst_busy", bus.conv_busy, 1'b0);
    check("rst_acc", bus.acc_sd, 16'h0000);
    check("rst_out", bus.out_data, 9'd0);
    check("rst_ovf", bus.ovf, 1'b0);
    check("rst_err", bus.sd_err, 1'b0);
    check("rst_ready", bus.in_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
